// File: rtl/ex_mem_if.sv
// Execute-to-memory stage bus: execute-side beat (in_*) and memory-side head (out_*).
// The stage uses the slave modport; its environment uses master.
interface ex_mem_if #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_result;
  logic [DATA_W-1:0]     in_remainder;
  logic                  in_zero;
  logic                  in_ovf;
  logic [3:0]            in_alu_ctrl;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_reg_write;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_result;
  logic [DATA_W-1:0]     out_remainder;
  logic                  out_zero;
  logic                  out_ovf;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_reg_write;
  logic                  out_rem_write;

  modport master (
    output in_valid, in_result, in_remainder, in_zero, in_ovf, in_alu_ctrl, in_rd, in_reg_write,
    input  in_ready,
    input  out_valid, out_result, out_remainder, out_zero, out_ovf, out_rd, out_reg_write, out_rem_write,
    output out_ready
  );

  modport slave (
    input  in_valid, in_result, in_remainder, in_zero, in_ovf, in_alu_ctrl, in_rd, in_reg_write,
    output in_ready,
    output out_valid, out_result, out_remainder, out_zero, out_ovf, out_rd, out_reg_write, out_rem_write,
    input  out_ready
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage with flush and saturating overflow-event counter.
// EX_MEM_SKID_EN: 2-entry skid buffer with registered in_ready; undefined: single register.
module ex_mem_stage #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_mem_if.slave          bus,
  input  logic             flush,
  input  logic             ovf_clear,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [DATA_W-1:0]     remainder;
    logic                  zero;
    logic                  ovf;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  rem_write;
  } beat_t;

  state_t state;
  beat_t  beat_in;
  beat_t  head;
  logic   out_valid_q;
  logic   accept;
  logic   deq;
  logic   ctrl_ok;
`ifdef EX_MEM_SKID_EN
  beat_t  skid;
  logic   in_ready_q;
`endif

  // Unknown ALU codes become a harmless "zero, no write" beat so x never leaves the ALU.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    beat_in    = '0;
    beat_in.rd = bus.in_rd;
    ctrl_ok    = bus.in_alu_ctrl inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111};
    if (ctrl_ok) begin
      beat_in.result    = bus.in_result;
      beat_in.remainder = bus.in_remainder;
      beat_in.zero      = bus.in_zero;
      beat_in.ovf       = bus.in_ovf;
      beat_in.reg_write = bus.in_reg_write;
      beat_in.rem_write = (bus.in_alu_ctrl == 4'b0011) && bus.in_reg_write;
    end else begin
      beat_in.zero = 1'b1;
    end
  end

`ifdef EX_MEM_SKID_EN
  assign bus.in_ready = in_ready_q;
`else
  assign bus.in_ready = bus.out_ready | ~out_valid_q;
`endif

  assign accept = bus.in_valid & bus.in_ready;
  assign deq    = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset too, because the outputs must read 0 out of reset.
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      head        <= '0;
`ifdef EX_MEM_SKID_EN
      skid        <= '0;
      in_ready_q  <= 1'b1;
`endif
    end else if (flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
`ifdef EX_MEM_SKID_EN
      in_ready_q  <= 1'b1;
`endif
    end else begin
      case (state)
        EMPTY: if (accept) begin
          head        <= beat_in;
          state       <= ONE;
          out_valid_q <= 1'b1;
        end
        ONE: begin
          if (accept && deq) begin
            head <= beat_in;
`ifdef EX_MEM_SKID_EN
          end else if (accept) begin
            skid       <= beat_in;
            state      <= FULL;
            in_ready_q <= 1'b0;
`endif
          end else if (deq) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
`ifdef EX_MEM_SKID_EN
        FULL: if (deq) begin
          head       <= skid;
          state      <= ONE;
          in_ready_q <= 1'b1;
        end
`endif
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_result    = head.result;
  assign bus.out_remainder = head.remainder;
  assign bus.out_zero      = head.zero;
  assign bus.out_ovf       = head.ovf;
  assign bus.out_rd        = head.rd;
  assign bus.out_reg_write = head.reg_write;
  assign bus.out_rem_write = head.rem_write;

  // Counts raw in_ovf of accepted beats; a flushed beat never counts, clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_count <= '0;
    end else if (accept && bus.in_ovf && !flush && (ovf_count != '1)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; expectations follow EX_MEM_SKID_EN.
module tb_ex_mem_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       ovf_clear;
  logic [7:0] ovf_count;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_ovf;

  ex_mem_if #(.DATA_W(64), .REG_ADDR_W(5)) bus ();

  ex_mem_stage #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .ovf_clear (ovf_clear),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic set_beat(input logic v, input logic [63:0] res, input logic [63:0] rem,
                          input logic [3:0] ctrl, input logic [4:0] rd, input logic rw,
                          input logic z, input logic o);
    bus.in_valid     = v;
    bus.in_result    = res;
    bus.in_remainder = rem;
    bus.in_alu_ctrl  = ctrl;
    bus.in_rd        = rd;
    bus.in_reg_write = rw;
    bus.in_zero      = z;
    bus.in_ovf       = o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; ovf_clear = 1'b0; bus.out_ready = 1'b0;
    set_beat(0, 64'h0, 64'h0, 4'h0, 5'd0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_result !== 64'h0) begin errors++; $display("FAIL rst_out_result: got %h want 0", bus.out_result); end
    checks++; if (bus.out_rd !== 5'd0 || bus.out_reg_write !== 1'b0) begin errors++; $display("FAIL rst_out_ctl: got rd=%0d rw=%b want 0/0", bus.out_rd, bus.out_reg_write); end
    checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL rst_ovf_count: got %0d want 0", ovf_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_beat(1, 64'h5, 64'h0, 4'b0010, 5'd3, 1, 0, 0);
    @(negedge clk);
    set_beat(0, 64'h0, 64'h0, 4'h0, 5'd0, 0, 0, 0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_result !== 64'h5) begin errors++; $display("FAIL lat_result: got %h want 5", bus.out_result); end
    checks++; if (bus.out_rd !== 5'd3) begin errors++; $display("FAIL lat_rd: got %0d want 3", bus.out_rd); end
    checks++; if (bus.out_zero !== 1'b0 || bus.out_reg_write !== 1'b1) begin errors++; $display("FAIL lat_flags: got z=%b rw=%b want 0/1", bus.out_zero, bus.out_reg_write); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    @(negedge clk);
    set_beat(1, 64'h1111, 64'h0, 4'b0000, 5'd1, 1, 0, 0);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_rdy0: got %b want 1", bus.in_ready); end
`ifdef EX_MEM_SKID_EN
    @(negedge clk);
    set_beat(1, 64'h2222, 64'h0, 4'b0000, 5'd2, 1, 0, 0);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_rdy1: got %b want 1", bus.in_ready); end
    @(negedge clk);
    set_beat(1, 64'h3333, 64'h0, 4'b0000, 5'd3, 1, 0, 0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_full: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_result !== 64'h1111) begin errors++; $display("FAIL stall_headA: got %h want 1111", bus.out_result); end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0 || bus.out_result !== 64'h1111) begin errors++; $display("FAIL stall_hold: got rdy=%b res=%h want 0/1111", bus.in_ready, bus.out_result); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_result !== 64'h2222 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_B: got res=%h rdy=%b want 2222/1", bus.out_result, bus.in_ready); end
`else
    @(negedge clk);
    set_beat(1, 64'h2222, 64'h0, 4'b0000, 5'd2, 1, 0, 0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_full: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_result !== 64'h1111) begin errors++; $display("FAIL stall_headA: got %h want 1111", bus.out_result); end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0 || bus.out_result !== 64'h1111) begin errors++; $display("FAIL stall_hold: got rdy=%b res=%h want 0/1111", bus.in_ready, bus.out_result); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_comb_rdy: got %b want 1", bus.in_ready); end
    @(negedge clk);
    set_beat(1, 64'h3333, 64'h0, 4'b0000, 5'd3, 1, 0, 0);
    checks++; if (bus.out_result !== 64'h2222) begin errors++; $display("FAIL stall_B: got %h want 2222", bus.out_result); end
`endif
    @(negedge clk);
    set_beat(0, 64'h0, 64'h0, 4'h0, 5'd0, 0, 0, 0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 64'h3333 || bus.out_rd !== 5'd3) begin errors++; $display("FAIL stall_C: got v=%b res=%h rd=%0d want 1/3333/3", bus.out_valid, bus.out_result, bus.out_rd); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_divide();
    bus.out_ready = 1'b1;
    @(negedge clk);
    set_beat(1, 64'h7, 64'h2, 4'b0011, 5'd4, 1, 0, 0);
    @(negedge clk);
    checks++; if (bus.out_rem_write !== 1'b1 || bus.out_remainder !== 64'h2 || bus.out_result !== 64'h7) begin errors++; $display("FAIL div_rem: got rw=%b rem=%h res=%h want 1/2/7", bus.out_rem_write, bus.out_remainder, bus.out_result); end
    set_beat(1, 64'h7, 64'h2, 4'b0110, 5'd4, 1, 0, 0);
    @(negedge clk);
    checks++; if (bus.out_rem_write !== 1'b0 || bus.out_result !== 64'h7 || bus.out_reg_write !== 1'b1) begin errors++; $display("FAIL sub_norem: got remw=%b res=%h rw=%b want 0/7/1", bus.out_rem_write, bus.out_result, bus.out_reg_write); end
    set_beat(1, 64'h7, 64'h2, 4'b0011, 5'd4, 0, 0, 0);
    @(negedge clk);
    set_beat(0, 64'h0, 64'h0, 4'h0, 5'd0, 0, 0, 0);
    checks++; if (bus.out_rem_write !== 1'b0 || bus.out_reg_write !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL div_nowrite: got remw=%b rw=%b v=%b want 0/0/1", bus.out_rem_write, bus.out_reg_write, bus.out_valid); end
    @(negedge clk);
  endtask

  task automatic test_invalid_ctrl();
    bus.out_ready = 1'b1;
    @(negedge clk);
    set_beat(1, 64'hDEAD, 64'h9, 4'b1111, 5'd6, 1, 0, 0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 64'h0 || bus.out_zero !== 1'b1) begin errors++; $display("FAIL bad1111_res: got v=%b res=%h z=%b want 1/0/1", bus.out_valid, bus.out_result, bus.out_zero); end
    checks++; if (bus.out_reg_write !== 1'b0 || bus.out_rem_write !== 1'b0) begin errors++; $display("FAIL bad1111_wr: got rw=%b remw=%b want 0/0", bus.out_reg_write, bus.out_rem_write); end
    set_beat(1, 64'h77, 64'h0, 4'b0100, 5'd6, 1, 0, 0);
    @(negedge clk);
    set_beat(0, 64'h0, 64'h0, 4'h0, 5'd0, 0, 0, 0);
    checks++; if (bus.out_result !== 64'h0 || bus.out_zero !== 1'b1 || bus.out_reg_write !== 1'b0) begin errors++; $display("FAIL bad0100: got res=%h z=%b rw=%b want 0/1/0", bus.out_result, bus.out_zero, bus.out_reg_write); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    ovf_clear = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    ovf_clear = 1'b0;
    set_beat(1, 64'hA, 64'h0, 4'b0000, 5'd1, 1, 0, 1);
    @(negedge clk);
    set_beat(1, 64'hB, 64'h0, 4'b0000, 5'd2, 1, 0, 1);
    @(negedge clk);
`ifdef EX_MEM_SKID_EN
    exp_ovf = 8'd2;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_full: got %b want 0", bus.in_ready); end
`else
    exp_ovf = 8'd1;
`endif
    set_beat(1, 64'hC, 64'h0, 4'b0000, 5'd3, 1, 0, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    set_beat(0, 64'h0, 64'h0, 4'h0, 5'd0, 0, 0, 0);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty: got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
    checks++; if (ovf_count !== exp_ovf) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", ovf_count, exp_ovf); end
    set_beat(1, 64'hD, 64'h0, 4'b0000, 5'd4, 1, 0, 0);
    @(negedge clk);
    set_beat(1, 64'hE, 64'h0, 4'b0000, 5'd5, 1, 0, 1);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_acc_rdy: got %b want 1", bus.in_ready); end
    @(negedge clk);
    flush = 1'b0;
    set_beat(0, 64'h0, 64'h0, 4'h0, 5'd0, 0, 0, 0);
    checks++; if (bus.out_valid !== 1'b0 || ovf_count !== exp_ovf) begin errors++; $display("FAIL flush_drop: got v=%b cnt=%0d want 0/%0d", bus.out_valid, ovf_count, exp_ovf); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_ovf_saturate();
    ovf_clear = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    ovf_clear = 1'b0;
    set_beat(1, 64'h1, 64'h0, 4'b0000, 5'd1, 1, 0, 1);
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 150) begin
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL thru_stream: got rdy=%b v=%b want 1/1", bus.in_ready, bus.out_valid); end
      end
      if (i == 254) begin
        checks++; if (ovf_count !== 8'd254) begin errors++; $display("FAIL ovf_254: got %0d want 254", ovf_count); end
      end
      if (i == 255) begin
        checks++; if (ovf_count !== 8'd255) begin errors++; $display("FAIL ovf_255: got %0d want 255", ovf_count); end
      end
    end
    checks++; if (ovf_count !== 8'd255) begin errors++; $display("FAIL ovf_sat: got %0d want 255", ovf_count); end
    ovf_clear = 1'b1;
    @(negedge clk);
    ovf_clear = 1'b0;
    checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL ovf_clear_prio: got %0d want 0", ovf_count); end
    @(negedge clk);
    set_beat(0, 64'h0, 64'h0, 4'h0, 5'd0, 0, 0, 0);
    checks++; if (ovf_count !== 8'd1) begin errors++; $display("FAIL ovf_after_clr: got %0d want 1", ovf_count); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    set_beat(1, 64'hBEEF, 64'h0, 4'b0001, 5'd9, 1, 0, 1);
    @(negedge clk);
    set_beat(0, 64'h0, 64'h0, 4'h0, 5'd0, 0, 0, 0);
    checks++; if (bus.out_valid !== 1'b1 || ovf_count !== 8'd2) begin errors++; $display("FAIL mid_pre: got v=%b cnt=%0d want 1/2", bus.out_valid, ovf_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_result !== 64'h0 || bus.out_rd !== 5'd0) begin errors++; $display("FAIL mid_rst_out: got v=%b res=%h rd=%0d want 0/0/0", bus.out_valid, bus.out_result, bus.out_rd); end
    checks++; if (ovf_count !== 8'd0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_state: got cnt=%0d rdy=%b want 0/1", ovf_count, bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_divide();
    test_invalid_ctrl();
    test_flush();
    test_ovf_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage that captures each ALU result beat and holds it for the memory/writeback side. It buffers the result, zero flag, overflow flag and divide remainder together with destination-register control using a valid/ready handshake and a 2-entry skid buffer, so the execute stage never sees a combinational ready path. It also supports a pipeline flush and keeps a saturating overflow-event counter. It sits directly downstream of the 64-bit ALU top level.

## Interface
- DATA_W, 64, width of result and remainder
- REG_ADDR_W, 5, destination register index width
- CNT_W, 8, overflow event counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute beat present
- in_ready  out  1  stage can accept a beat
- in_result  in  DATA_W  ALU result
- in_remainder  in  DATA_W  divider remainder
- in_zero  in  1  ALU zero flag
- in_ovf  in  1  ALU overflow flag
- in_alu_ctrl  in  4  ALU control code of this beat
- in_rd  in  REG_ADDR_W  destination register
- in_reg_write  in  1  beat writes a register
- flush  in  1  discard all buffered and incoming beats
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_result, out_remainder  out  DATA_W  head payload
- out_zero, out_ovf  out  1  head flags
- out_rd  out  REG_ADDR_W  head destination
- out_reg_write  out  1  head register write enable
- out_rem_write  out  1  head also writes remainder (divide)
- ovf_count  out  CNT_W  saturating count of accepted overflow beats
- ovf_clear  in  1  synchronous clear of ovf_count

## Operation
- Accept on `in_valid & in_ready`; dequeue on `out_valid & out_ready`. Strict FIFO order.
- Valid ALU codes are 0000, 0001, 0010, 0011, 0110 and 0111.
  - For any other code, capture result = 0, zero = 1, ovf = 0, reg_write = 0, rem_write = 0.
  - These beats are still passed through, so the ALU's x output never propagates.
- out_rem_write = 1 only when ctrl = 0011 and reg_write = 1. Otherwise out_remainder is captured but ignored.
- State machine (registered occupancy): EMPTY, ONE, FULL.
  - EMPTY: accept → ONE.
  - ONE: accept only → FULL (new beat to skid); dequeue only → EMPTY; both → ONE (new beat becomes head).
  - FULL: dequeue → ONE (skid moves to head). No accept is possible.
- in_ready = (state != FULL). It is purely a function of registered state.
- flush: next state is EMPTY. Both entries are dropped, and a beat accepted in the same cycle is discarded. flush has priority over all transitions.
- ovf_count: increments by 1 for each accepted beat with in_ovf = 1 that is not flushed in the same cycle.
  - Saturates at 2^CNT_W − 1.
  - ovf_clear has priority: a clear plus an increment in the same cycle gives 0.

## Timing
- Reset (async assert, sync release): state EMPTY, in_ready = 1, out_valid = 0, all payload outputs 0, ovf_count = 0.
- Latency: accept in cycle N (EMPTY) → out_valid = 1 in cycle N+1.
- Throughput: 1 beat per cycle when out_ready is held high.
- Stall: out_ready low for 2 cycles fills ONE then FULL. in_ready drops the cycle after the second accept.
- Outputs are stable while `out_valid & ~out_ready`.
- Reset mid-operation: all buffered beats are lost immediately, and outputs go to their reset values without waiting for a clock.

## Configuration
- EX_MEM_SKID_EN defined: 2-entry skid buffer as described above. in_ready is registered.
- EX_MEM_SKID_EN undefined: single register, states EMPTY and ONE only. in_ready = out_ready | ~out_valid (combinational). Latency and flush/counter rules are unchanged.

## Test plan
- Reset, then accept result 0x5, ctrl 0010, rd 3, reg_write 1 → cycle+1: out_valid 1, out_result 0x5, out_rd 3, out_zero 0.
- Hold out_ready 0 and present 3 back-to-back beats A, B, C → A and B accepted, in_ready 0, C held. Raise out_ready → outputs A, B, C in order with no loss or duplication.
- Divide beat: ctrl 0011, result 7, remainder 2, reg_write 1 → out_rem_write 1, out_remainder 2. Same beat with ctrl 0110 → out_rem_write 0.
- Beat with ctrl 1111 → out_result 0, out_zero 1, out_reg_write 0.
- FULL state, then flush together with an incoming beat → next cycle out_valid 0, in_ready 1, ovf_count unchanged.
- 300 accepted ovf beats → ovf_count 255. Then ovf_clear together with an ovf beat → 0.
